// File: rtl/half_duplex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_pkg
// Description : Shared types for the half-duplex tri-state byte bus endpoint.
//               port_state_t reports bus direction, hp_state_t is the
//               endpoint sequencer state, c_default_width the bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package half_duplex_pkg;

    localparam int c_default_width = 8;

    typedef enum logic {
        IS_INPUT  = 1'b0,
        IS_OUTPUT = 1'b1
    } port_state_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        TURN_ON  = 3'd2,
        DRIVE    = 3'd3,
        TURN_OFF = 3'd4
    } hp_state_t;

endpackage
`default_nettype wire

// File: rtl/hp_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hp_tx_fifo
// Description : Synchronous transmit FIFO. Push is ignored when full, pop is
//               ignored when empty; a simultaneous push and pop keeps the
//               count. pop_data shows the head entry (first-word fall-through).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               push, push_data     - write strobe and data
//               pop                 - remove head entry
//               pop_data            - head entry
//               full, empty, count  - occupancy, derived from registered count
// Revision    : 1.0 - initial release
// ============================================================================
module hp_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                  c_aw         = $clog2(DEPTH);
    localparam logic [c_aw-1:0]     c_ptr_one    = 1;
    localparam logic [c_aw:0]       c_cnt_one    = 1;
    localparam logic [c_aw:0]       c_full_count = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push && (r_count != c_full_count);
    assign w_pop    = pop && (r_count != '0);
    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == c_full_count);
    assign empty    = (r_count == '0);
    assign count    = r_count;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/half_duplex_port.sv
`default_nettype none
// ============================================================================
// Module      : half_duplex_port
// Description : Endpoint of a shared tri-state byte bus. Queues bytes for
//               transmission, requests the bus, inserts high-Z turnaround
//               cycles around its drive window, receives peer bytes and flags
//               drive contention.
// Ports       : clk, rst                    - clock, synchronous reset
//               tx_data/tx_valid/tx_ready   - transmit push interface
//               rx_data/rx_valid            - received byte, one-cycle pulse
//               bus_req/bus_gnt             - ownership handshake
//               port_state                  - IS_OUTPUT while driving
//               collision                   - sticky contention flag
//               io_port/io_stb              - shared bus and byte strobe
// Revision    : 1.0 - initial release
// ============================================================================
module half_duplex_port
    import half_duplex_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int TX_DEPTH   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [WIDTH-1:0]  rx_data,
    output logic              rx_valid,
    output logic              bus_req,
    input  logic              bus_gnt,
    output port_state_t       port_state,
    output logic              collision,
    inout  wire  [WIDTH-1:0]  io_port,
    inout  wire               io_stb
);

    // Turnaround counter reload; each turnaround state lasts TURNAROUND cycles.
    localparam logic [1:0] c_turn_last = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    hp_state_t                  r_state;
    logic [1:0]                 r_turn_cnt;
    logic                       r_bus_req;
    port_state_t                r_port_state;
    logic [WIDTH-1:0]           r_drv_data;
    logic [WIDTH-1:0]           r_rx_data;
    logic                       r_rx_valid;
    logic                       r_collision;

    logic [WIDTH-1:0]           w_fifo_data;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [$clog2(TX_DEPTH):0]  w_fifo_count;
    logic                       w_push;
    logic                       w_load;

    assign tx_ready   = !w_fifo_full;
    assign w_push     = tx_valid && !w_fifo_full;
    assign bus_req    = r_bus_req;
    assign port_state = r_port_state;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign collision  = r_collision;

    // Bus enable is the registered direction, so the bus only moves on edges.
    assign io_port = (r_port_state == IS_OUTPUT) ? r_drv_data : {WIDTH{1'bz}};
    assign io_stb  = (r_port_state == IS_OUTPUT) ? 1'b1 : 1'bz;

    hp_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (tx_data),
        .pop       (w_load),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // A byte is popped on the same edge it is loaded into the drive register,
    // i.e. at the start of the cycle it occupies the bus.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            REQ:     w_load = bus_gnt && (TURNAROUND == 0);
            TURN_ON: w_load = (r_turn_cnt == 2'd0) && !w_fifo_empty;
            DRIVE:   w_load = bus_gnt && (w_fifo_count != '0);
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_turn_cnt   <= 2'd0;
            r_bus_req    <= 1'b0;
            r_port_state <= IS_INPUT;
            r_drv_data   <= '0;
        end else begin
            if (w_load) begin
                r_drv_data <= w_fifo_data;
            end
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_state   <= REQ;
                        r_bus_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        if (TURNAROUND == 0) begin
                            r_state      <= DRIVE;
                            r_port_state <= IS_OUTPUT;
                        end else begin
                            r_state    <= TURN_ON;
                            r_turn_cnt <= c_turn_last;
                        end
                    end
                end
                TURN_ON: begin
                    if (r_turn_cnt == 2'd0) begin
                        r_state      <= DRIVE;
                        r_port_state <= IS_OUTPUT;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 2'd1;
                    end
                end
                DRIVE: begin
                    // Losing the grant lets the current byte finish; the rest
                    // stay queued and IDLE will re-request them.
                    if (!w_load) begin
                        r_port_state <= IS_INPUT;
                        r_bus_req    <= 1'b0;
                        if (TURNAROUND == 0) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= TURN_OFF;
                            r_turn_cnt <= c_turn_last;
                        end
                    end
                end
                TURN_OFF: begin
                    if (r_turn_cnt == 2'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_bus_req    <= 1'b0;
                    r_port_state <= IS_INPUT;
                end
            endcase
        end
    end

    // Receive whenever we are not the driver; an undriven or unknown strobe
    // is treated as no strobe. Contention is checked against our own drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state != DRIVE) begin
                if (io_stb === 1'b1) begin
                    r_rx_data  <= io_port;
                    r_rx_valid <= 1'b1;
                end
            end else begin
                if ((io_port !== r_drv_data) || (io_stb !== 1'b1)) begin
                    r_collision <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
